// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: request latch, SCAN scheduling, travel and door timing.
// Optional seven-segment floor display output is enabled by defining FLOOR_SEG_EN.
module elevator_car_ctrl #(
    parameter int N_FLOORS      = 9,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] int_req,
    input  logic [N_FLOORS-1:0] ext_up_req,
    input  logic [N_FLOORS-1:0] ext_down_req,
    input  logic                sensor_trip,
    input  logic                stop,
    output logic                move_up,
    output logic                move_down,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
`ifdef FLOOR_SEG_EN
    output logic [13:0]         floor_disp,
`endif
    output logic                idle
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    // Hall up-call at the top floor and down-call at the bottom floor are meaningless.
    localparam logic [N_FLOORS-1:0] UP_MASK   = ~(N_FLOORS'(1) << (N_FLOORS - 1));
    localparam logic [N_FLOORS-1:0] DOWN_MASK = ~N_FLOORS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    state_t              r_state;
    dir_t                r_dir;
    logic [TW-1:0]       r_travel_cnt;
    logic [DW-1:0]       r_door_cnt;
    logic [FLOOR_W-1:0]  r_cur_floor;
    logic [N_FLOORS-1:0] r_pending;
    logic                r_move_up;
    logic                r_move_down;
    logic                r_door_open;
    logic                r_idle;

    state_t              w_state_nxt;
    dir_t                w_dir_nxt;
    logic [TW-1:0]       w_travel_nxt;
    logic [DW-1:0]       w_door_nxt;
    logic [FLOOR_W-1:0]  w_floor_nxt;
    logic [FLOOR_W-1:0]  w_step_floor;
    logic [N_FLOORS-1:0] w_new_req;
    logic [N_FLOORS-1:0] w_clear;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic                w_move_up_nxt;
    logic                w_move_down_nxt;
    logic                w_door_open_nxt;
    logic                w_idle_nxt;

    function automatic logic [N_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] fl);
        logic [N_FLOORS-1:0] v;
        for (int i = 0; i < N_FLOORS; i++) begin
            v[i] = (FLOOR_W'(i) == fl);
        end
        return v;
    endfunction

    function automatic logic req_beyond(input logic [N_FLOORS-1:0] req,
                                        input logic [FLOOR_W-1:0]  fl,
                                        input dir_t                dir);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            hit = hit | (req[i] & ((dir == DIR_UP) ? (FLOOR_W'(i) > fl) : (FLOOR_W'(i) < fl)));
        end
        return hit;
    endfunction

    // Next-state, counter, floor, request-latch and output decode.
    always_comb begin
        w_new_req       = int_req | (ext_up_req & UP_MASK) | (ext_down_req & DOWN_MASK);
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_travel_nxt    = r_travel_cnt;
        w_door_nxt      = r_door_cnt;
        w_floor_nxt     = r_cur_floor;
        w_clear         = '0;
        w_move_up_nxt   = 1'b0;
        w_move_down_nxt = 1'b0;
        w_door_open_nxt = r_door_open;
        w_step_floor    = (r_dir == DIR_UP) ? (r_cur_floor + FLOOR_W'(1)) : (r_cur_floor - FLOOR_W'(1));

        if (stop) begin
            // Frozen, but the open door still swallows calls for its own floor.
            if (r_state == ST_DOOR) begin
                w_clear = floor_bit(r_cur_floor);
            end else begin
                w_clear = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_door_open_nxt = 1'b0;
                    if (|(r_pending & floor_bit(r_cur_floor))) begin
                        w_state_nxt     = ST_DOOR;
                        w_door_nxt      = DOOR_LOAD;
                        w_door_open_nxt = 1'b1;
                        w_clear         = floor_bit(r_cur_floor);
                    end else if (req_beyond(r_pending, r_cur_floor, r_dir)) begin
                        w_state_nxt     = ST_MOVING;
                        w_travel_nxt    = TRAVEL_LOAD;
                        w_move_up_nxt   = (r_dir == DIR_UP);
                        w_move_down_nxt = (r_dir == DIR_DOWN);
                    end else if (req_beyond(r_pending, r_cur_floor,
                                            (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP)) begin
                        w_dir_nxt       = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                        w_state_nxt     = ST_MOVING;
                        w_travel_nxt    = TRAVEL_LOAD;
                        w_move_up_nxt   = (r_dir == DIR_DOWN);
                        w_move_down_nxt = (r_dir == DIR_UP);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_MOVING: begin
                    w_door_open_nxt = 1'b0;
                    if (r_travel_cnt == '0) begin
                        w_floor_nxt = w_step_floor;
                        if (|(r_pending & floor_bit(w_step_floor))) begin
                            w_state_nxt     = ST_DOOR;
                            w_door_nxt      = DOOR_LOAD;
                            w_door_open_nxt = 1'b1;
                            w_clear         = floor_bit(w_step_floor);
                        end else if (req_beyond(r_pending, w_step_floor, r_dir)) begin
                            w_travel_nxt    = TRAVEL_LOAD;
                            w_move_up_nxt   = (r_dir == DIR_UP);
                            w_move_down_nxt = (r_dir == DIR_DOWN);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_travel_nxt    = r_travel_cnt - TW'(1);
                        w_move_up_nxt   = (r_dir == DIR_UP);
                        w_move_down_nxt = (r_dir == DIR_DOWN);
                    end
                end
                ST_DOOR: begin
                    w_clear         = floor_bit(r_cur_floor);
                    w_door_open_nxt = 1'b1;
                    if (sensor_trip || (|(w_new_req & floor_bit(r_cur_floor)))) begin
                        w_door_nxt = DOOR_LOAD;
                    end else if (r_door_cnt == '0) begin
                        w_state_nxt     = ST_IDLE;
                        w_door_open_nxt = 1'b0;
                    end else begin
                        w_door_nxt = r_door_cnt - DW'(1);
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_door_open_nxt = 1'b0;
                end
            endcase
        end

        w_pending_nxt = (r_pending | w_new_req) & ~w_clear;
        w_idle_nxt    = (w_state_nxt == ST_IDLE) && (w_pending_nxt == '0);
    end

    // State, counters, floor, pending set and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_UP;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
            r_cur_floor  <= '0;
            r_pending    <= '0;
            r_move_up    <= 1'b0;
            r_move_down  <= 1'b0;
            r_door_open  <= 1'b0;
            r_idle       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_dir        <= w_dir_nxt;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
            r_cur_floor  <= w_floor_nxt;
            r_pending    <= w_pending_nxt;
            r_move_up    <= w_move_up_nxt;
            r_move_down  <= w_move_down_nxt;
            r_door_open  <= w_door_open_nxt;
            r_idle       <= w_idle_nxt;
        end
    end

    assign move_up   = r_move_up;
    assign move_down = r_move_down;
    assign door_open = r_door_open;
    assign cur_floor = r_cur_floor;
    assign pending   = r_pending;
    assign idle      = r_idle;

`ifdef FLOOR_SEG_EN
    logic [13:0] r_floor_disp;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Displayed floor is one-based; a leading zero tens digit is blanked.
    function automatic logic [13:0] disp_of(input logic [FLOOR_W-1:0] fl);
        int         v;
        logic [3:0] tens;
        logic [3:0] ones;
        v    = int'(fl) + 32'sd1;
        tens = 4'(v / 32'sd10);
        ones = 4'(v % 32'sd10);
        return {((tens == 4'd0) ? 7'h00 : seg7(tens)), seg7(ones)};
    endfunction

    // Display register tracks the floor register edge for edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_floor_disp <= {7'h00, 7'h06};
        end else begin
            r_floor_disp <= disp_of(w_floor_nxt);
        end
    end

    assign floor_disp = r_floor_disp;
`endif

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a floor/timer level behavioural model.
module tb_elevator_car_ctrl;
    localparam int N  = 9;
    localparam int FW = 4;
    localparam int T  = 4;
    localparam int D  = 6;
    localparam int VW = FW + N + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  int_req = '0;
    logic [N-1:0]  ext_up_req = '0;
    logic [N-1:0]  ext_down_req = '0;
    logic          sensor_trip = 1'b0;
    logic          stop = 1'b0;
    logic          move_up, move_down, door_open, idle;
    logic [FW-1:0] cur_floor;
    logic [N-1:0]  pending;

    int checks = 0;
    int failures = 0;

    elevator_car_ctrl #(.N_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .ext_up_req(ext_up_req),
        .ext_down_req(ext_down_req), .sensor_trip(sensor_trip), .stop(stop),
        .move_up(move_up), .move_down(move_down), .door_open(door_open),
        .cur_floor(cur_floor), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 travelling, 2 door; m_timer = cycles left in the current phase.
    int m_mode = 0, m_floor = 0, m_timer = 0;
    bit m_up = 1'b1;
    bit m_pend[N];
    bit m_old[N];
    bit e_mu = 1'b0, e_md = 1'b0, e_door = 1'b0, e_idle = 1'b1;
    int door_q[$];
    bit prev_door = 1'b0;

    function automatic bit work_beyond(int f, bit up_dir);
        for (int g = 0; g < N; g++)
            if (m_old[g] && (up_dir ? (g > f) : (g < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start_move();
        m_mode = 1; m_timer = T; e_mu = m_up; e_md = !m_up;
    endtask

    task automatic open_door(int f);
        m_mode = 2; m_timer = D; m_pend[f] = 1'b0; e_door = 1'b1;
    endtask

    task automatic model_edge();
        bit req[N];
        bit any;
        if (reset) begin
            m_mode = 0; m_floor = 0; m_timer = 0; m_up = 1'b1;
            for (int g = 0; g < N; g++) m_pend[g] = 1'b0;
            e_mu = 1'b0; e_md = 1'b0; e_door = 1'b0; e_idle = 1'b1;
            return;
        end
        for (int g = 0; g < N; g++) begin
            req[g] = int_req[g] | ((g < N-1) && ext_up_req[g]) | ((g > 0) && ext_down_req[g]);
            m_old[g] = m_pend[g];
            if (req[g]) m_pend[g] = 1'b1;
        end
        e_mu = 1'b0; e_md = 1'b0;
        if (stop) begin
            if (m_mode == 2) m_pend[m_floor] = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    e_door = 1'b0;
                    if (m_old[m_floor]) open_door(m_floor);
                    else if (work_beyond(m_floor, m_up)) start_move();
                    else if (work_beyond(m_floor, !m_up)) begin m_up = !m_up; start_move(); end
                end
                1: begin
                    if (m_timer > 1) begin
                        m_timer--; e_mu = m_up; e_md = !m_up;
                    end else begin
                        m_floor += m_up ? 1 : -1;
                        if (m_old[m_floor]) open_door(m_floor);
                        else if (work_beyond(m_floor, m_up)) start_move();
                        else m_mode = 0;
                    end
                end
                default: begin
                    m_pend[m_floor] = 1'b0;
                    if (sensor_trip || req[m_floor]) m_timer = D;
                    else if (m_timer > 1) m_timer--;
                    else begin m_mode = 0; e_door = 1'b0; end
                end
            endcase
        end
        any = 1'b0;
        for (int g = 0; g < N; g++) any |= m_pend[g];
        e_idle = (m_mode == 0) && !any;
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0] p;
        for (int g = 0; g < N; g++) p[g] = m_pend[g];
        return {e_mu, e_md, e_door, FW'(m_floor), p, e_idle};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (door_open && !prev_door) door_q.push_back(int'(cur_floor));
        prev_door = door_open;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++;
        if ({move_up, move_down, door_open, cur_floor, pending, idle} !== {3'b000, 4'd0, 9'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h",
                     {move_up, move_down, door_open, cur_floor, pending, idle}, {3'b000, 4'd0, 9'd0, 1'b1});
        end
    endtask

    task automatic test_single_call();
        int first_move = -1, door_cycles = 0;
        int_req[6] = 1'b1; tick(); int_req = '0;
        checks++;
        if (pending !== 9'h040) begin failures++; $display("FAIL latch_6: got %h expected %h", pending, 9'h040); end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (move_up && first_move < 0) first_move = k;
            if (door_open) door_cycles++;
            checks++;
            if ({move_up, move_down, door_open, cur_floor, pending, idle} !== model_vec()) begin
                failures++;
                $display("FAIL single_call_cyc%0d: got %h expected %h", k,
                         {move_up, move_down, door_open, cur_floor, pending, idle}, model_vec());
            end
        end
        checks++;
        if (first_move !== 1) begin failures++; $display("FAIL first_move_edge: got %0d expected 1", first_move); end
        checks++;
        if (door_cycles !== D) begin failures++; $display("FAIL door_len: got %0d expected %0d", door_cycles, D); end
        checks++;
        if ({cur_floor, pending, idle} !== {4'd6, 9'd0, 1'b1}) begin
            failures++; $display("FAIL arrive_6: got %h expected %h", {cur_floor, pending, idle}, {4'd6, 9'd0, 1'b1});
        end
    endtask

    task automatic test_scan_order();
        reset = 1'b1; tick(); reset = 1'b0;
        door_q.delete();
        int_req[6] = 1'b1; ext_up_req[3] = 1'b1; tick(); int_req = '0; ext_up_req = '0;
        repeat (70) tick();
        checks++;
        if (door_q.size() != 2 || door_q[0] != 3 || door_q[1] != 6) begin
            failures++; $display("FAIL scan_order: got %p expected '{3,6}", door_q);
        end
    endtask

    task automatic test_reverse();
        checks++;
        if ({cur_floor, idle} !== {4'd6, 1'b1}) begin
            failures++; $display("FAIL rev_start: got %h expected %h", {cur_floor, idle}, {4'd6, 1'b1});
        end
        door_q.delete();
        int_req[8] = 1'b1; int_req[2] = 1'b1; tick(); int_req = '0;
        for (int k = 0; k < 60; k++) begin
            tick();
            checks++;
            if ({move_up, move_down, door_open, cur_floor, pending, idle} !== model_vec()) begin
                failures++;
                $display("FAIL reverse_cyc%0d: got %h expected %h", k,
                         {move_up, move_down, door_open, cur_floor, pending, idle}, model_vec());
            end
        end
        checks++;
        if (door_q.size() != 2 || door_q[0] != 8 || door_q[1] != 2) begin
            failures++; $display("FAIL reverse_order: got %p expected '{8,2}", door_q);
        end
    endtask

    task automatic test_sensor();
        int after = -1;
        int_req[2] = 1'b1; tick(); int_req = '0; tick();
        checks++;
        if (door_open !== 1'b1) begin failures++; $display("FAIL sensor_open: got %b expected 1", door_open); end
        sensor_trip = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (door_open !== 1'b1) begin failures++; $display("FAIL sensor_hold%0d: got %b expected 1", k, door_open); end
        end
        sensor_trip = 1'b0;
        for (int k = 1; k <= 20 && after < 0; k++) begin
            tick();
            if (!door_open) after = k;
        end
        checks++;
        if (after !== D) begin failures++; $display("FAIL sensor_close: got %0d expected %0d", after, D); end
    endtask

    task automatic test_stop();
        int rem = 0;
        bit stepped = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        int_req[1] = 1'b1; tick(); int_req = '0;
        tick(); tick();
        stop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({move_up, cur_floor} !== {1'b0, 4'd0}) begin
                failures++; $display("FAIL stop_freeze%0d: got %h expected %h", k, {move_up, cur_floor}, {1'b0, 4'd0});
            end
        end
        stop = 1'b0;
        for (int k = 0; k < 10 && !stepped; k++) begin
            tick();
            if (cur_floor != 4'd0) stepped = 1'b1;
            else if (move_up) rem++;
        end
        checks++;
        if (!stepped || rem !== T - 2) begin
            failures++; $display("FAIL stop_resume: got rem=%0d stepped=%b expected rem=%0d stepped=1", rem, stepped, T - 2);
        end
    endtask

    task automatic test_edges();
        reset = 1'b1; tick(); reset = 1'b0;
        ext_up_req[8] = 1'b1; ext_down_req[0] = 1'b1; tick(); ext_up_req = '0; ext_down_req = '0;
        checks++;
        if ({pending, idle} !== {9'd0, 1'b1}) begin
            failures++; $display("FAIL masked_calls: got %h expected %h", {pending, idle}, {9'd0, 1'b1});
        end
        int_req[0] = 1'b1; tick(); int_req = '0; tick();
        checks++;
        if ({move_up, move_down, door_open, cur_floor, pending} !== {3'b001, 4'd0, 9'd0}) begin
            failures++; $display("FAIL here_call: got %h expected %h",
                                 {move_up, move_down, door_open, cur_floor, pending}, {3'b001, 4'd0, 9'd0});
        end
        reset = 1'b1; tick(); reset = 1'b0;
        int_req[5] = 1'b1; tick(); int_req = '0;
        repeat (6) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({move_up, move_down, door_open, cur_floor, pending, idle} !== {3'b000, 4'd0, 9'd0, 1'b1}) begin
            failures++; $display("FAIL reset_mid_travel: got %h expected %h",
                                 {move_up, move_down, door_open, cur_floor, pending, idle}, {3'b000, 4'd0, 9'd0, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            int_req      = N'($urandom & $urandom & $urandom);
            ext_up_req   = N'($urandom & $urandom & $urandom & $urandom);
            ext_down_req = N'($urandom & $urandom & $urandom & $urandom);
            sensor_trip  = ($urandom_range(15, 0) == 0);
            stop         = ($urandom_range(31, 0) == 0);
            reset        = ($urandom_range(599, 0) == 0);
            tick();
            checks++;
            if ({move_up, move_down, door_open, cur_floor, pending, idle} !== model_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d: got %h expected %h", k,
                         {move_up, move_down, door_open, cur_floor, pending, idle}, model_vec());
            end
            checks++;
            if ((move_up && move_down) || ((move_up || move_down) && door_open) || (cur_floor > 4'(N - 1))) begin
                failures++;
                $display("FAIL random_invariant%0d: got up=%b dn=%b door=%b floor=%0d expected exclusive outputs, floor<%0d",
                         k, move_up, move_down, door_open, cur_floor, N);
            end
        end
        int_req = '0; ext_up_req = '0; ext_down_req = '0;
        sensor_trip = 1'b0; stop = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan_order();
        test_reverse();
        test_sensor();
        test_stop();
        test_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
